// File: rtl/calc_pkg.sv
// Shared constants, op codes and state encoding for the calculator arithmetic sequencer.
package calc_pkg;

  localparam int CALC_W     = 8;
  localparam int CALC_ITERS = 8;
  localparam int ITER_CNT_W = $clog2(CALC_ITERS);

  localparam logic [ITER_CNT_W-1:0] ITER_LAST  = ITER_CNT_W'(CALC_ITERS - 1);
  localparam logic [15:0]           ERR_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } calc_state_e;

endpackage

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV controller driving a shared external 8-bit adder.
// Define CALC_DIV_EN to build the restoring divider; otherwise DIV reports an error.
module calc_op_sequencer
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_carry,
  output logic        flag_err,
  output logic [7:0]  adder_a,
  output logic [7:0]  adder_b,
  output logic        adder_cin,
  input  logic [7:0]  adder_sum,
  input  logic        adder_cout
);

  calc_state_e           state_q, state_d;
  calc_op_e              op_q, op_d;
  logic [7:0]            a_q, a_d;
  logic [7:0]            b_q, b_d;
  logic [7:0]            acc_q, acc_d;   // MUL high half / DIV remainder
  logic [7:0]            mq_q, mq_d;     // MUL multiplier-product / DIV quotient
  logic [ITER_CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [15:0]           result_q, result_d;
  logic                  flag_carry_q, flag_carry_d;
  logic                  flag_err_q, flag_err_d;
`ifdef CALC_DIV_EN
  logic [8:0]            trial_s;
  logic                  div_ok_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      acc_q        <= 8'h00;
      mq_q         <= 8'h00;
      iter_cnt_q   <= '0;
      result_q     <= 16'h0000;
      flag_carry_q <= 1'b0;
      flag_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      mq_q         <= mq_d;
      iter_cnt_q   <= iter_cnt_d;
      result_q     <= result_d;
      flag_carry_q <= flag_carry_d;
      flag_err_q   <= flag_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    mq_d         = mq_q;
    iter_cnt_d   = iter_cnt_q;
    result_d     = result_q;
    flag_carry_d = flag_carry_q;
    flag_err_d   = flag_err_q;
    adder_a      = 8'h00;
    adder_b      = 8'h00;
    adder_cin    = 1'b0;
`ifdef CALC_DIV_EN
    trial_s      = {acc_q, mq_q[7]};
    div_ok_s     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_EXEC;
          op_d       = calc_op_e'(op);
          a_d        = a;
          b_d        = b;
          iter_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            adder_a      = a_q;
            adder_b      = b_q;
            adder_cin    = 1'b0;
            result_d     = {7'b0000000, adder_cout, adder_sum};
            flag_carry_d = adder_cout;
            flag_err_d   = 1'b0;
            state_d      = ST_DONE;
          end
          OP_SUB: begin
            adder_a      = a_q;
            adder_b      = ~b_q;
            adder_cin    = 1'b1;
            result_d     = {8'h00, adder_sum};
            flag_carry_d = ~adder_cout;
            flag_err_d   = 1'b0;
            state_d      = ST_DONE;
          end
          OP_MUL: begin
            acc_d   = 8'h00;
            mq_d    = b_q;
            state_d = ST_ITER;
          end
`ifdef CALC_DIV_EN
          OP_DIV: begin
            if (b_q == 8'h00) begin
              result_d     = ERR_RESULT;
              flag_carry_d = 1'b0;
              flag_err_d   = 1'b1;
              state_d      = ST_DONE;
            end else begin
              acc_d   = 8'h00;
              mq_d    = a_q;
              state_d = ST_ITER;
            end
          end
`endif
          default: begin
            result_d     = ERR_RESULT;
            flag_carry_d = 1'b0;
            flag_err_d   = 1'b1;
            state_d      = ST_DONE;
          end
        endcase
      end

      ST_ITER: begin
        iter_cnt_d = iter_cnt_q + 3'd1;
        case (op_q)
          OP_MUL: begin
            adder_a = acc_q;
            adder_b = a_q;
            if (mq_q[0]) begin
              acc_d = {adder_cout, adder_sum[7:1]};
              mq_d  = {adder_sum[0], mq_q[7:1]};
            end else begin
              acc_d = {1'b0, acc_q[7:1]};
              mq_d  = {acc_q[0], mq_q[7:1]};
            end
          end
`ifdef CALC_DIV_EN
          OP_DIV: begin
            // Trial subtract of b from the shifted partial remainder.
            adder_a   = trial_s[7:0];
            adder_b   = ~b_q;
            adder_cin = 1'b1;
            div_ok_s  = trial_s[8] | adder_cout;
            acc_d     = div_ok_s ? adder_sum : trial_s[7:0];
            mq_d      = {mq_q[6:0], div_ok_s};
          end
`endif
          default: begin
            acc_d = acc_q;
            mq_d  = mq_q;
          end
        endcase
        if (iter_cnt_q == ITER_LAST) begin
          state_d      = ST_DONE;
          result_d     = {acc_d, mq_d};
          flag_carry_d = (op_q == OP_MUL) ? (acc_d != 8'h00) : 1'b0;
          flag_err_d   = 1'b0;
        end else begin
          state_d = ST_ITER;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign result     = result_q;
  assign flag_carry = flag_carry_q;
  assign flag_err   = flag_err_q;

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle arithmetic controller for the calculator datapath. It accepts one operation per start/done handshake and sequences a shared external 8-bit ripple adder to produce ADD, SUB, MUL and DIV results. MUL is shift-add and DIV is restoring; both take 8 adder iterations. The block sits between the keypad/operand registers and the display formatter, and is the sole driver of the adder's inputs.

## Interface
- No parameters. Operand width is fixed at 8 and the iteration count at 8, via package constants.
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request; sampled only in IDLE.
- `op`  in  2  — operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `a`, `b`  in  8 each  — operands, unsigned; captured when start is accepted.
- `busy`  out  1  — high in every non-IDLE state.
- `done`  out  1  — one-cycle pulse; result and flags are valid from this cycle.
- `result`  out  16  — registered result; held until the next accepted start.
- `flag_carry`  out  1  — carry, borrow or overflow (see Operation).
- `flag_err`  out  1  — divide-by-zero, or unsupported op.
- `adder_a`, `adder_b`  out  8 each  — adder operands.
- `adder_cin`  out  1  — adder carry-in.
- `adder_sum`  in  8  — combinational adder sum, same cycle.
- `adder_cout`  in  1  — combinational adder carry-out, same cycle.

## Operation
- **States:** IDLE, EXEC, ITER, DONE.
- **IDLE → EXEC** on start. This edge captures a, b and op, and clears `iter_cnt`.
- **ADD (in EXEC):** adder_a = a, adder_b = b, cin = 0.
  - result = {7'b0, cout, sum}; flag_carry = cout.
  - Then → DONE.
- **SUB (in EXEC):** adder_a = a, adder_b = ~b, cin = 1.
  - result = {8'h00, sum}; flag_carry = ~cout (borrow).
  - Then → DONE.
- **MUL:** EXEC initialises acc = 0 and mq = b, then → ITER.
  - Each ITER cycle drives adder_a = acc, adder_b = a_reg, cin = 0.
  - If mq[0] = 1: {acc, mq} ← {cout, sum, mq} >> 1.
  - If mq[0] = 0: {acc, mq} ← {1'b0, acc, mq} >> 1.
  - After 8 iterations: result = {acc, mq}; flag_carry = (acc != 0).
- **DIV:** if b = 0, EXEC → DONE with result = 16'hFFFF, flag_err = 1, flag_carry = 0.
  - Otherwise EXEC sets rem = 0 and q = a, then → ITER.
  - Each ITER cycle forms the 9-bit value r' = {rem, q[7]}.
  - Adder inputs: adder_a = r'[7:0], adder_b = ~b_reg, cin = 1.
  - ok = r'[8] | cout.
  - rem ← ok ? sum : r'[7:0]; q ← {q[6:0], ok}.
  - After 8 iterations: result = {rem, q}; flag_carry = 0.
- **ITER → DONE** when iter_cnt = 7. The counter increments once per ITER cycle.
- **DONE:** done = 1 for this cycle, then → IDLE unconditionally.
- **Adder drive outside EXEC/ITER:** adder_a = 0, adder_b = 0, cin = 0.
- **start while busy:** ignored, not queued. A start held high through DONE is accepted in the following IDLE cycle.
- **Flag lifetime:** flag_err and flag_carry update only at DONE entry and hold with result.
- **Reset:** from any state, including mid-ITER, go to IDLE.
  - result = 0, flags = 0, busy = 0, done = 0.
  - Iteration registers are cleared; no done pulse is emitted for the aborted operation.

## Timing
- Start is sampled at edge k.
- busy rises after edge k.
- ADD, SUB and DIV-by-zero: done is high in the cycle after edge k+1.
- MUL and DIV: done is high in the cycle after edge k+9.
- busy falls after the DONE cycle, so the minimum start-to-start spacing is 3 cycles (ADD) or 10 cycles (MUL/DIV).
- The adder is combinational. adder_sum/adder_cout are consumed in the same cycle they are driven; there is no adder pipeline stage.

## Configuration
- Macro: `CALC_DIV_EN`.
- **Defined:** DIV implemented as above.
- **Undefined:** the DIV state logic and the remainder/trial datapath are compiled out.
  - op = 11 goes EXEC → DONE with result = 16'hFFFF, flag_err = 1, flag_carry = 0.
  - Timing as for divide-by-zero.

## Structure
- Shared package `calc_pkg` holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - state encoding;
  - CALC_W = 8 and CALC_ITERS = 8;
  - ERR_RESULT = 16'hFFFF.
- No sub-module. The adder is instantiated by the parent and wired to the adder_* ports, so the block can be verified against a behavioural adder model.

## Test plan
- ADD a=200, b=100 at edge k → done in cycle after k+1, result = 0x012C, flag_carry = 1, flag_err = 0.
- SUB a=5, b=9 → result = 0x00FC, flag_carry = 1 (borrow). SUB a=9, b=5 → 0x0004, flag_carry = 0.
- MUL a=255, b=255 → done in cycle after k+9, result = 0xFE01, flag_carry = 1. MUL 12×10 → 0x0078, flag_carry = 0.
- DIV a=200, b=7 → result = 0x041C (rem 4, quotient 28), done after k+9.
  - DIV b=0 → result 0xFFFF, flag_err = 1, done after k+1.
  - With CALC_DIV_EN undefined, DIV 200/7 → 0xFFFF, flag_err = 1.
- start pulsed again during MUL busy → ignored, a single done.
  - rst asserted at ITER iteration 4 → next cycle busy = 0, result = 0, no done.
  - A following ADD 1+1 → result 0x0002.
- start held high continuously with ADD → done pulses every 3 cycles; adder inputs are 0 in IDLE/DONE cycles.
